mulf_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision multiplier, the counterpart of the combinational divider in the float unit. It shares the divider's operand/result/zero-flag conventions. It trades combinational area for a 24-iteration shift-add mantissa datapath under a start/done handshake. The ALU sequencer issues operands and collects the result.

---
 rtl/float_pkg.sv | 17 +
 rtl/mant_mul_seq.sv | 33 +++
 rtl/mulf_seq.sv | 104 ++++++++++
 tb/tb_mulf_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// float_pkg: IEEE-754 single constants, field helpers and FSM states shared by the float unit
package float_pkg;
  localparam int          FLT_BIAS    = 127;
  localparam int          FLT_EXP_MAX = 255;
  localparam logic [31:0] FLT_QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] FLT_INF_MAG = 31'h7F80_0000;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  function automatic logic f_sign(input logic [31:0] f);
    return f[31];
  endfunction
  function automatic logic [7:0] f_exp(input logic [31:0] f);
    return f[30:23];
  endfunction
  function automatic logic [22:0] f_mant(input logic [31:0] f);
    return f[22:0];
  endfunction
endpackage

// File: rtl/mant_mul_seq.sv
// mant_mul_seq: iterative unsigned NxN shift-add multiplier (clk, rst_n, load, x, y -> product, valid)
module mant_mul_seq #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] product,
  output logic           valid
);
  localparam int LW = $clog2(N + 1);
  logic [N-1:0]  mx;
  logic [LW-1:0] left;
  logic [N:0]    sum;
  // the multiplier lives in the low half of the accumulator and is consumed LSB first
  assign sum   = {1'b0, product[2*N-1:N]} + {1'b0, product[0] ? mx : {N{1'b0}}};
  assign valid = ~|left;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      product <= '0;
      mx      <= '0;
      left    <= '0;
    end else if (load) begin
      product <= {{N{1'b0}}, y};
      mx      <= x;
      left    <= LW'(N);
    end else if (!valid) begin
      product <= {sum, product[N-1:1]};
      left    <= left - 1'b1;
    end
endmodule

// File: rtl/mulf_seq.sv
// mulf_seq: multi-cycle IEEE-754 single multiplier with start/done handshake
//   start/a/b in; busy high during MUL+NORM, done one-cycle pulse; s product, ze signed-zero flag
module mulf_seq
  import float_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [EXP_W+MANT_W:0]   a,
  input  logic [EXP_W+MANT_W:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+MANT_W:0]   s,
  output logic                    ze
);
  localparam int W  = EXP_W + MANT_W + 1;
  localparam int M  = MANT_W + 1;
  localparam int P  = 2 * M;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(M);
  localparam logic [W-2:0] INF  = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  state_t               state, nxt;
  logic [CW-1:0]        cnt;
  logic [W-2:0]         ra, rb;
  logic                 sg;
  logic signed [EW-1:0] esum, e1;
  logic [P-1:0]         prod;
  logic                 pvalid, accept;
  logic [EXP_W-1:0]     ea, eb;
  logic [MANT_W-1:0]    mant;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                 inv, inf_op, zero_op, ovf, unf;
  logic [W-1:0]         res_s;
  logic                 res_z;
  assign accept = state == IDLE && start;
  assign busy   = state == MUL || state == NORM;
  assign done   = state == DONE;
  assign nxt = state == IDLE ? (start ? MUL : IDLE) :
               state == MUL  ? (cnt == CW'(M - 1) ? NORM : MUL) :
               state == NORM ? DONE : IDLE;
  mant_mul_seq #(.N(M)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .x       ({1'b1, a[MANT_W-1:0]}),
    .y       ({1'b1, b[MANT_W-1:0]}),
    .product (prod),
    .valid   (pvalid)
  );
  assign ea     = ra[W-2:MANT_W];
  assign eb     = rb[W-2:MANT_W];
  assign a_nan  = &ea && |ra[MANT_W-1:0];
  assign b_nan  = &eb && |rb[MANT_W-1:0];
  assign a_inf  = &ea && ~|ra[MANT_W-1:0];
  assign b_inf  = &eb && ~|rb[MANT_W-1:0];
  // exponent 0 covers both true zero and flushed denormals
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  // product of two [1,2) mantissas lies in [1,4): the top bit selects the normalising shift
  assign e1   = esum + {{(EW-1){1'b0}}, prod[P-1]};
  assign mant = MANT_W'(prod[P-1] ? prod >> M : prod >> (M - 1));
  assign inv     = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign inf_op  = a_inf || b_inf;
  assign zero_op = a_zero || b_zero;
  assign ovf     = e1 >= E_MAX;
  assign unf     = e1 <= 0;
  assign res_s = inv     ? QNAN :
                 inf_op  ? {sg, INF} :
                 zero_op ? {sg, {(W-1){1'b0}}} :
                 ovf     ? {sg, INF} :
                 unf     ? {sg, {(W-1){1'b0}}} :
                           {sg, e1[EXP_W-1:0], mant};
  assign res_z = !inv && !inf_op && (zero_op || (!ovf && unf));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      sg    <= 1'b0;
      esum  <= '0;
      s     <= '0;
      ze    <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= state == MUL ? cnt + 1'b1 : '0;
      if (accept) begin
        ra   <= a[W-2:0];
        rb   <= b[W-2:0];
        sg   <= a[W-1] ^ b[W-1];
        esum <= {2'b00, a[W-2:MANT_W]} + {2'b00, b[W-2:MANT_W]} - EW'(BIAS);
      end
      if (state == NORM && pvalid) begin
        s  <= res_s;
        ze <= res_z;
      end
    end
endmodule

// File: tb/tb_mulf_seq.sv
// tb_mulf_seq: directed and random checks of mulf_seq against an arithmetic reference model
module tb_mulf_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] a = '0, b = '0, s;
  logic        busy, done, ze;
  int          nvec = 0, nbad = 0, ndone = 0;
  mulf_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .ze    (ze)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done === 1'b1) ndone++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r, output logic z);
    int ex, ey, e;
    logic sgn, nx, ny, ix, iy, zx, zy;
    longint unsigned p;
    logic [22:0] m;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    sgn = x[31] ^ y[31];
    nx  = ex == 255 && x[22:0] != 0;
    ny  = ey == 255 && y[22:0] != 0;
    ix  = ex == 255 && x[22:0] == 0;
    iy  = ey == 255 && y[22:0] == 0;
    zx  = ex == 0;
    zy  = ey == 0;
    p   = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    e   = ex + ey - 127;
    if (p >= 64'd1 << 47) begin
      m = 23'(p >> 24);
      e = e + 1;
    end else m = 23'(p >> 23);
    z = 1'b0;
    if (nx || ny || (ix && zy) || (iy && zx)) r = 32'h7FC0_0000;
    else if (ix || iy) r = {sgn, 31'h7F80_0000};
    else if (zx || zy) begin r = {sgn, 31'b0}; z = 1'b1; end
    else if (e >= 255) r = {sgn, 31'h7F80_0000};
    else if (e <= 0) begin r = {sgn, 31'b0}; z = 1'b1; end
    else r = {sgn, 8'(e), m};
  endtask
  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y, input int inj);
    logic [31:0] es;
    logic        ez, ok;
    int          d0;
    model(x, y, es, ez);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    ok = 1'b1;
    d0 = ndone;
    for (int k = 1; k <= 25; k++) begin
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
      start = k == inj;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".busy_window"}, {31'b0, ok}, 32'd1);
    chk({tag, ".done"}, {30'b0, done, busy}, 32'b10);
    chk({tag, ".s"}, s, es);
    chk({tag, ".ze"}, {31'b0, ze}, {31'b0, ez});
    @(negedge clk);
    chk({tag, ".one_done"}, ndone - d0, 32'd1);
  endtask
  function automatic logic [31:0] rnd();
    int c;
    logic [31:0] v;
    c = $urandom_range(0, 9);
    v = $urandom;
    if (c == 0) v[30:23] = 8'h00;
    else if (c == 1) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 1) v[22:0] = '0;
    end else if (c == 2) v[30:23] = 8'($urandom_range(1, 254));
    else v[30:23] = 8'($urandom_range(64, 190));
    return v;
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    chk("reset.s", s, 32'h0);
    chk("reset.flags", {29'b0, busy, done, ze}, 32'h0);
    rst_n = 1'b1;
    run("mul_1p5x2", 32'h3FC0_0000, 32'h4000_0000, 0);
    chk("dir.1p5x2", s, 32'h4040_0000);
    run("neg5x3", 32'hC0A0_0000, 32'h4040_0000, 0);
    chk("dir.neg5x3", s, 32'hC170_0000);
    run("neg3xneg3", 32'hC040_0000, 32'hC040_0000, 0);
    chk("dir.neg3xneg3", s, 32'h4110_0000);
    run("zero", 32'h0000_0000, 32'h40E0_0000, 0);
    chk("dir.zero", {ze, s[30:0]}, 32'h8000_0000);
    run("negzero", 32'h8000_0000, 32'h40E0_0000, 0);
    chk("dir.negzero", s, 32'h8000_0000);
    run("ovf", 32'h7180_0000, 32'h7180_0000, 0);
    chk("dir.ovf", s, 32'h7F80_0000);
    run("unf", 32'h0D80_0000, 32'h0D80_0000, 0);
    chk("dir.unf", {ze, s[30:0]}, 32'h8000_0000);
    run("infxzero", 32'h7F80_0000, 32'h0000_0000, 0);
    chk("dir.infxzero", {31'b0, ze}, 32'h0);
    run("second_start", 32'h4080_0000, 32'h4080_0000, 5);
    chk("dir.second_start", s, 32'h4180_0000);
    @(negedge clk);
    a = 32'h4040_0000; b = 32'h4040_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.s", s, 32'h0);
    chk("abort.flags", {29'b0, busy, done, ze}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_reset", 32'hC0A0_0000, 32'h3F00_0000, 0);
    chk("dir.after_reset", s, 32'hC020_0000);
    for (int i = 0; i < 150; i++) run("rand", rnd(), rnd(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
